// File: rtl/bcd_gate_ctrl_pkg.sv
// Shared types and constants for the BCD gate controller.
// State encoding, BCD full-scale value and digit width.
package bcd_gate_ctrl_pkg;

  localparam int unsigned DigitW = 4;
  localparam int unsigned BcdW   = 2 * DigitW;

  localparam logic [BcdW-1:0] BcdMax = 8'h99;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClr    = 3'd1,
    StGate   = 3'd2,
    StSettle = 3'd3,
    StLatch  = 3'd4
  } state_e;

endpackage

// File: rtl/sig_sync_edge.sv
// Synchroniser chain plus history flop; emits a registered one-cycle pulse per rising edge.
// Total latency from d rising to rise high is STAGES+1 cycles.
module sig_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              rise_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~hist_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/bcd_gate_ctrl.sv
// Gate-window sequencer for an external 2-digit BCD counter.
// Define BCD_GATE_CONT_EN for free-running back-to-back windows; default is single-shot.
module bcd_gate_ctrl
  import bcd_gate_ctrl_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned TW          = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            sig_in,
  input  logic [BcdW-1:0] cnt_val,
  output logic            cnt_x,
  output logic            cnt_clr,
  output logic [BcdW-1:0] result,
  output logic            result_vld,
  output logic            ovf,
  output logic            busy
);

  localparam logic [TW-1:0] TimerLoad = TW'(GATE_CYCLES - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ovf_acc_q, ovf_acc_d;
  logic [BcdW-1:0] result_q;
  logic            ovf_q;
  logic            vld_q;
  logic            rise;

  sig_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sig_in),
    .rise (rise)
  );

  // Edges outside the gate window are dropped, so SETTLE sees a stable count.
  assign cnt_x   = rise & (state_q == StGate);
  assign cnt_clr = (state_q == StClr);
  assign busy    = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ovf_acc_d = ovf_acc_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StClr;
      end
      StClr: begin
        timer_d   = TimerLoad;
        ovf_acc_d = 1'b0;
        state_d   = StGate;
      end
      StGate: begin
        if (timer_q == '0) begin
          state_d = StSettle;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      StSettle: state_d = StLatch;
      StLatch: begin
`ifdef BCD_GATE_CONT_EN
        state_d = StClr;
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
    // Counter wraps 99 -> 00 on this increment.
    if (cnt_x && (cnt_val == BcdMax)) ovf_acc_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      ovf_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ovf_acc_q <= ovf_acc_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= (state_q == StLatch);
      if (state_q == StLatch) begin
        result_q <= cnt_val;
        ovf_q    <= ovf_acc_q;
      end
    end
  end

  assign result     = result_q;
  assign ovf        = ovf_q;
  assign result_vld = vld_q;

endmodule

// File: tb/tb_bcd_gate_ctrl.sv
// Directed bench for bcd_gate_ctrl with a behavioural BCD counter on the count interface.
// Build with BCD_GATE_CONT_EN to exercise the free-running mode instead of single-shot.
module tb_bcd_gate_ctrl;

  localparam int G = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       sig_in = 1'b0;
  logic [7:0] cnt_val;
  logic       cnt_x, cnt_clr, result_vld, ovf, busy;
  logic [7:0] result;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  int vld_cnt = 0;
  int stray = 0;
  int busy_drop = 0;
  bit watch_busy = 1'b0;
  int t_clr, t_vld, t_prev, base;

  bcd_gate_ctrl #(
    .GATE_CYCLES(G),
    .TW         (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sig_in    (sig_in),
    .cnt_val   (cnt_val),
    .cnt_x     (cnt_x),
    .cnt_clr   (cnt_clr),
    .result    (result),
    .result_vld(result_vld),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd9) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Behavioural 2-digit BCD counter driven by the DUT.
  logic [7:0] cnt = 8'h00;
  always @(posedge clk or negedge reset) begin
    if (!reset)       cnt <= 8'h00;
    else if (cnt_clr) cnt <= 8'h00;
    else if (cnt_x)   cnt <= bcd_inc(cnt);
  end
  assign cnt_val = cnt;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (result_vld === 1'b1) vld_cnt++;
    if (cnt_x === 1'b1 && (busy !== 1'b1 || cnt_clr === 1'b1)) stray++;
    if (watch_busy && busy !== 1'b1) busy_drop++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      cycles(hi);
      sig_in = 1'b0;
      cycles(lo);
    end
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    chk({tag, "_clr"}, int'(cnt_clr), 1);
    t_clr = cyc_cnt;
  endtask

  task automatic wait_vld(input string tag, output int tv);
    int n = 0;
    while (result_vld !== 1'b1 && n < G + 50) begin
      @(negedge clk);
      n++;
    end
    if (result_vld !== 1'b1) chk({tag, "_timeout"}, 0, 1);
    tv = cyc_cnt;
  endtask

  initial begin
    cycles(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt_x", int'(cnt_x), 0);
    chk("rst_cnt_clr", int'(cnt_clr), 0);
    chk("rst_result", int'(result), 8'h00);
    chk("rst_vld", int'(result_vld), 0);
    chk("rst_ovf", int'(ovf), 0);
    reset = 1'b1;
    cycles(2);

`ifdef BCD_GATE_CONT_EN
    fork
      forever begin
        sig_in = 1'b1;
        cycles(2);
        sig_in = 1'b0;
        cycles(3);
      end
    join_none
    do_start("c0");
    watch_busy = 1'b1;
    wait_vld("c0", t_prev);
    chk("c0_dt", t_prev - t_clr, G + 3);
    for (int w = 1; w <= 3; w++) begin
      cycles(1);
      wait_vld("cw", t_vld);
      chk("cw_period", t_vld - t_prev, G + 3);
      chk("cw_result", int'(result), 8'h80);
      chk("cw_ovf", int'(ovf), 0);
      t_prev = t_vld;
    end
    chk("c_busy_drop", busy_drop, 0);
    chk("c_stray", stray, 0);
`else
    // 10 edges, period 10
    do_start("t1");
    pulses(10, 5, 5);
    wait_vld("t1", t_vld);
    chk("t1_dt", t_vld - t_clr, G + 3);
    chk("t1_result", int'(result), 8'h10);
    chk("t1_ovf", int'(ovf), 0);
    cycles(1);
    chk("t1_vld_pulse", int'(result_vld), 0);
    chk("t1_idle", int'(busy), 0);

    // 150 edges wrap the counter
    do_start("t2");
    pulses(150, 1, 1);
    wait_vld("t2", t_vld);
    chk("t2_result", int'(result), 8'h50);
    chk("t2_ovf", int'(ovf), 1);
    cycles(2);
    chk("t2_hold", int'(result), 8'h50);
    do_start("t2b");
    wait_vld("t2b", t_vld);
    chk("t2b_result", int'(result), 8'h00);
    chk("t2b_ovf", int'(ovf), 0);
    cycles(2);

    // edges only in IDLE, SETTLE and after LATCH
    pulses(5, 2, 2);
    do_start("t3");
    cycles(G - 2);
    sig_in = 1'b1;
    cycles(1);
    sig_in = 1'b0;
    cycles(1);
    sig_in = 1'b1;
    cycles(1);
    sig_in = 1'b0;
    wait_vld("t3", t_vld);
    chk("t3_result", int'(result), 8'h00);
    cycles(5);
    chk("t3_stray", stray, 0);

    // start re-pulsed mid-gate
    base = vld_cnt;
    do_start("t4");
    pulses(10, 2, 2);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    pulses(23, 2, 2);
    wait_vld("t4", t_vld);
    chk("t4_dt", t_vld - t_clr, G + 3);
    chk("t4_result", int'(result), 8'h33);
    cycles(20);
    chk("t4_vld_count", vld_cnt - base, 1);
    chk("t4_idle", int'(busy), 0);

    // reset mid-gate
    do_start("t5");
    pulses(20, 2, 2);
    reset = 1'b0;
    #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_cnt_clr", int'(cnt_clr), 0);
    chk("t5_cnt_x", int'(cnt_x), 0);
    chk("t5_result", int'(result), 8'h00);
    chk("t5_ovf", int'(ovf), 0);
    chk("t5_vld", int'(result_vld), 0);
    cycles(3);
    reset = 1'b1;
    base = vld_cnt;
    cycles(G + 10);
    chk("t5_no_vld", vld_cnt - base, 0);
    do_start("t5b");
    pulses(7, 3, 3);
    wait_vld("t5b", t_vld);
    chk("t5b_dt", t_vld - t_clr, G + 3);
    chk("t5b_result", int'(result), 8'h07);
    chk("t5b_ovf", int'(ovf), 0);
    chk("final_stray", stray, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
